// File: rtl/div_ctrl.sv
// div_ctrl: RV64M divide/remainder sequencer in front of an iterative 64/32-bit divider.
// Optional macro DIV_CTRL_REUSE_EN: reuse the last divider result for operand-identical requests.

module div_ctrl #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic             req_word,
   input  logic [63:0]      req_src1,
   input  logic [63:0]      req_src2,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [63:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             div_valid,
   output logic             div_flush,
   output logic             div_divw,
   output logic             div_signed,
   output logic [63:0]      div_dividend,
   output logic [63:0]      div_divisor,
   input  logic             div_ready,
   input  logic             div_out_valid,
   input  logic [63:0]      div_quotient,
   input  logic [63:0]      div_remainder
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [1:0]  op;
   logic        word;
   logic [63:0] src1;
   logic [63:0] src2;
   logic        accept;
   logic        capture;
   logic        div_zero;
   logic        sgn_ovf;
   logic        rec_hit;
   logic        fast_hit;
   logic [63:0] spec_quot;
   logic [63:0] spec_rem;
   logic [63:0] rec_data;
   logic [63:0] fast_data;

   function automatic logic [63:0] fmt_result(input logic is_word, input logic [63:0] val);
      logic [63:0] res;
      if (is_word) begin
         res = {{32{val[31]}}, val[31:0]};
      end else begin
         res = val;
      end
      return res;
   endfunction

   // Divide-by-zero and signed-overflow detection on the incoming request.
   always_comb begin
      div_zero = 1'b0;
      sgn_ovf  = 1'b0;
      if (req_word) begin
         div_zero = (req_src2[31:0] == 32'd0);
         sgn_ovf  = !req_op[0] && (req_src1[31:0] == 32'h8000_0000) &&
                    (req_src2[31:0] == 32'hFFFF_FFFF);
      end else begin
         div_zero = (req_src2 == 64'd0);
         sgn_ovf  = !req_op[0] && (req_src1 == 64'h8000_0000_0000_0000) &&
                    (req_src2 == 64'hFFFF_FFFF_FFFF_FFFF);
      end
      if (div_zero) begin
         spec_quot = 64'hFFFF_FFFF_FFFF_FFFF;
         spec_rem  = req_src1;
      end else begin
         spec_quot = req_src1;
         spec_rem  = 64'd0;
      end
   end

`ifdef DIV_CTRL_REUSE_EN
   logic        rec_valid;
   logic        rec_signed;
   logic        rec_word;
   logic [63:0] rec_src1;
   logic [63:0] rec_src2;
   logic [63:0] rec_quot;
   logic [63:0] rec_rem;

   // Lookup of the last divider-completed operation.
   always_comb begin
      rec_hit = rec_valid && (req_src1 == rec_src1) && (req_src2 == rec_src2) &&
                (!req_op[0] == rec_signed) && (req_word == rec_word);
      if (req_op[1]) begin
         rec_data = fmt_result(req_word, rec_rem);
      end else begin
         rec_data = fmt_result(req_word, rec_quot);
      end
   end

   // Record is written only on divider completion, so flush never needs to clear it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rec_valid  <= 1'b0;
         rec_signed <= 1'b0;
         rec_word   <= 1'b0;
         rec_src1   <= 64'd0;
         rec_src2   <= 64'd0;
         rec_quot   <= 64'd0;
         rec_rem    <= 64'd0;
      end else if (capture) begin
         rec_valid  <= 1'b1;
         rec_signed <= !op[0];
         rec_word   <= word;
         rec_src1   <= src1;
         rec_src2   <= src2;
         rec_quot   <= div_quotient;
         rec_rem    <= div_remainder;
      end
   end
`else
   assign rec_hit  = 1'b0;
   assign rec_data = 64'd0;
`endif

   // Special cases take priority over the reuse record.
   always_comb begin
      fast_hit = div_zero || sgn_ovf || rec_hit;
      if (div_zero || sgn_ovf) begin
         if (req_op[1]) begin
            fast_data = fmt_result(req_word, spec_rem);
         end else begin
            fast_data = fmt_result(req_word, spec_quot);
         end
      end else begin
         fast_data = rec_data;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and divider handshake decode.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      capture    = 1'b0;
      div_valid  = 1'b0;
      div_flush  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid && !flush && !rst) begin
               accept = 1'b1;
               if (fast_hit) begin
                  next_state = S_DONE;
               end else begin
                  next_state = S_ISSUE;
               end
            end else begin
               next_state = S_IDLE;
            end
         end
         S_ISSUE: begin
            div_valid = !flush && !rst;
            if (flush) begin
               next_state = S_IDLE;
            end else if (div_ready) begin
               next_state = S_WAIT;
            end else begin
               next_state = S_ISSUE;
            end
         end
         S_WAIT: begin
            div_flush = flush && !rst;
            if (flush) begin
               next_state = S_IDLE;
            end else if (div_out_valid) begin
               capture    = 1'b1;
               next_state = S_DONE;
            end else begin
               next_state = S_WAIT;
            end
         end
         S_DONE: begin
            if (flush || resp_ready) begin
               next_state = S_IDLE;
            end else begin
               next_state = S_DONE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Request capture and response register; operands stay put until the next accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         op        <= 2'd0;
         word      <= 1'b0;
         src1      <= 64'd0;
         src2      <= 64'd0;
         resp_data <= 64'd0;
         resp_tag  <= '0;
      end else if (accept) begin
         op       <= req_op;
         word     <= req_word;
         src1     <= req_src1;
         src2     <= req_src2;
         resp_tag <= req_tag;
         if (fast_hit) begin
            resp_data <= fast_data;
         end
      end else if (capture) begin
         if (op[1]) begin
            resp_data <= fmt_result(word, div_remainder);
         end else begin
            resp_data <= fmt_result(word, div_quotient);
         end
      end
   end

   assign req_ready    = (state == S_IDLE) && !rst;
   assign resp_valid   = (state == S_DONE);
   assign div_divw     = word;
   assign div_signed   = !op[0];
   assign div_dividend = src1;
   assign div_divisor  = src2;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed steps plus randomized requests against an arithmetic model.
// A behavioural divider stands in for the real one (65/33 cycles from issue to result).

module tb_div_ctrl;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic             req_word;
   logic [63:0]      req_src1;
   logic [63:0]      req_src2;
   logic [TAG_W-1:0] req_tag;
   logic             resp_valid;
   logic             resp_ready;
   logic [63:0]      resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic             div_valid;
   logic             div_flush;
   logic             div_divw;
   logic             div_signed;
   logic [63:0]      div_dividend;
   logic [63:0]      div_divisor;
   logic             div_ready;
   logic             div_out_valid;
   logic [63:0]      div_quotient;
   logic [63:0]      div_remainder;

   int checks = 0;
   int errors = 0;
   logic [TAG_W-1:0] tag_ctr = '0;

   // model of the reuse record: last request that completed through the divider
   logic        rec_v = 1'b0;
   logic [63:0] rec_a = 64'd0;
   logic [63:0] rec_b = 64'd0;
   logic        rec_s = 1'b0;
   logic        rec_w = 1'b0;

   div_ctrl #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
      .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
      .div_valid(div_valid), .div_flush(div_flush), .div_divw(div_divw), .div_signed(div_signed),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_ready(div_ready), .div_out_valid(div_out_valid),
      .div_quotient(div_quotient), .div_remainder(div_remainder)
   );

   always #5 clk = ~clk;

   // RV64M result of a request, straight from the architectural rules
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                              input logic [63:0] a, input logic [63:0] b);
      logic [31:0] x, y, q32, r32, s32;
      logic [63:0] q64, r64;
      logic sgn;
      sgn = !op[0];
      x = a[31:0];
      y = b[31:0];
      if (word) begin
         if (y == 32'd0) begin q32 = 32'hFFFF_FFFF; r32 = x; end
         else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin q32 = x; r32 = 32'd0; end
         else if (sgn) begin q32 = $signed(x) / $signed(y); r32 = $signed(x) % $signed(y); end
         else begin q32 = x / y; r32 = x % y; end
         s32 = op[1] ? r32 : q32;
         return {{32{s32[31]}}, s32};
      end
      if (b == 64'd0) begin q64 = 64'hFFFF_FFFF_FFFF_FFFF; r64 = a; end
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
         q64 = a; r64 = 64'd0;
      end
      else if (sgn) begin q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b); end
      else begin q64 = a / b; r64 = a % b; end
      return op[1] ? r64 : q64;
   endfunction

   function automatic logic is_special(input logic [1:0] op, input logic word,
                                       input logic [63:0] a, input logic [63:0] b);
      if (word)
         return (b[31:0] == 32'd0) ||
                (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      return (b == 64'd0) ||
             (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
   endfunction

   function automatic int exp_latency(input logic [1:0] op, input logic word,
                                      input logic [63:0] a, input logic [63:0] b);
      if (is_special(op, word, a, b)) return 1;
`ifdef DIV_CTRL_REUSE_EN
      if (rec_v && a == rec_a && b == rec_b && (!op[0]) == rec_s && word == rec_w) return 1;
`endif
      return word ? 35 : 67;
   endfunction

   // behavioural divider: issue -> result after 65 (64-bit) or 33 (word) cycles
   logic        busy;
   int          cnt;
   logic [63:0] dq_full, dr_full;
   assign dq_full       = ref_result({1'b0, !div_signed}, div_divw, div_dividend, div_divisor);
   assign dr_full       = ref_result({1'b1, !div_signed}, div_divw, div_dividend, div_divisor);
   assign div_quotient  = div_divw ? {32'hA5A5_5A5A, dq_full[31:0]} : dq_full;
   assign div_remainder = div_divw ? {32'h5A5A_A5A5, dr_full[31:0]} : dr_full;
   assign div_ready     = !busy;
   assign div_out_valid = busy && (cnt == 1);

   always @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= 0;
      end else if (busy) begin
         if (div_flush || cnt == 1) busy <= 1'b0;
         cnt <= cnt - 1;
      end else if (div_valid) begin
         busy <= 1'b1;
         cnt  <= div_divw ? 33 : 65;
      end
   end

   task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, got, exp);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", name, got, exp);
      end
   endtask

   task automatic run_req(input string name, input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_data, input int hold);
      int exp_lat, lat;
      logic done, saw;
      logic [TAG_W-1:0] tag;
      exp_lat = exp_latency(op, word, a, b);
      tag = tag_ctr;
      tag_ctr = tag_ctr + 4'd1;
      @(negedge clk);
      check1({name, ":req_ready"}, req_ready, 1'b1);
      req_valid = 1'b1; req_op = op; req_word = word;
      req_src1 = a; req_src2 = b; req_tag = tag;
      lat = 0; done = 1'b0; saw = 1'b0;
      while (!done && lat < 200) begin
         @(negedge clk);
         req_valid = 1'b0;
         lat++;
         if (div_valid) saw = 1'b1;
         if (resp_valid) done = 1'b1;
      end
      check1({name, ":responded"}, done, 1'b1);
      check64({name, ":data"}, resp_data, exp_data);
      check64({name, ":latency"}, 64'(lat), 64'(exp_lat));
      check64({name, ":tag"}, 64'(resp_tag), 64'(tag));
      check1({name, ":div_valid_seen"}, saw, exp_lat > 1);
      if (exp_lat > 1) begin
         rec_v = 1'b1; rec_a = a; rec_b = b; rec_s = !op[0]; rec_w = word;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check1({name, ":hold_valid"}, resp_valid, 1'b1);
         check64({name, ":hold_data"}, resp_data, exp_data);
         check64({name, ":hold_tag"}, 64'(resp_tag), 64'(tag));
         check1({name, ":hold_req_ready"}, req_ready, 1'b0);
      end
      resp_ready = 1'b1;
      check1({name, ":consume_req_ready"}, req_ready, 1'b0);
      @(negedge clk);
      resp_ready = 1'b0;
      check1({name, ":after_valid"}, resp_valid, 1'b0);
      check1({name, ":after_req_ready"}, req_ready, 1'b1);
   endtask

   initial begin
      logic found;
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_word = 1'b0;
      req_src1 = 64'd0; req_src2 = 64'd0; req_tag = '0; resp_ready = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check1("rst:req_ready", req_ready, 1'b0);
      check1("rst:resp_valid", resp_valid, 1'b0);
      check1("rst:div_valid", div_valid, 1'b0);
      check1("rst:div_flush", div_flush, 1'b0);
      check64("rst:resp_data", resp_data, 64'd0);
      check64("rst:resp_tag", 64'(resp_tag), 64'd0);
      rst = 1'b0;
      #1;
      check1("rst:req_ready_release", req_ready, 1'b1);

      // divider path, 64-bit and word
      run_req("div_s64", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
      run_req("rem_s64", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_req("divuw", 2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'h0000_0000_0FFF_FFFF, 0);
      run_req("remw", 2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0);

      // special cases
      run_req("divu_zero", 2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_req("remu_zero", 2'b11, 1'b0, 64'd5, 64'd0, 64'd5, 0);
      run_req("divw_ovf", 2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 0);
      run_req("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);

      // backpressure on a divider result
      run_req("backpressure", 2'b11, 1'b0, 64'd1000, 64'd33, 64'd10, 10);

      // flush in WAIT at T+20
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_word = 1'b0;
      req_src1 = 64'd1000; req_src2 = 64'd3; req_tag = tag_ctr;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (19) @(negedge clk);
      flush = 1'b1;
      #1;
      check1("flush20:div_flush", div_flush, 1'b1);
      check1("flush20:div_valid", div_valid, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      check1("flush20:idle", req_ready, 1'b1);
      found = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (resp_valid) found = 1'b1;
      end
      check1("flush20:no_resp", found, 1'b0);
      run_req("divu_after_flush", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 0);

      // flush on the same cycle as div_out_valid
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_word = 1'b0;
      req_src1 = 64'd12345; req_src2 = 64'd11; req_tag = tag_ctr;
      @(negedge clk);
      req_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (div_out_valid) found = 1'b1;
      end
      check1("flushov:div_out_valid", found, 1'b1);
      flush = 1'b1;
      #1;
      check1("flushov:div_flush", div_flush, 1'b1);
      @(negedge clk);
      flush = 1'b0;
      check1("flushov:no_resp", resp_valid, 1'b0);
      check1("flushov:idle", req_ready, 1'b1);

      // reuse candidate pair
      run_req("div_100_7", 2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 0);
      run_req("rem_100_7", 2'b10, 1'b0, 64'd100, 64'd7, 64'd2, 0);

      // reset in the middle of a divide abandons it and clears the record
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_word = 1'b0;
      req_src1 = 64'd99999; req_src2 = 64'd13; req_tag = tag_ctr;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check1("midrst:req_ready", req_ready, 1'b0);
      @(negedge clk);
      check1("midrst:resp_valid", resp_valid, 1'b0);
      check1("midrst:div_valid", div_valid, 1'b0);
      check1("midrst:div_flush", div_flush, 1'b0);
      check64("midrst:resp_data", resp_data, 64'd0);
      check64("midrst:resp_tag", 64'(resp_tag), 64'd0);
      rst = 1'b0;
      rec_v = 1'b0;
      #1;
      check1("midrst:req_ready_release", req_ready, 1'b1);
      run_req("rem_after_rst", 2'b10, 1'b0, 64'd100, 64'd7, 64'd2, 0);

      // randomized requests
      for (int k = 0; k < 10; k++) begin
         logic [1:0]  rop;
         logic        rw;
         logic [63:0] ra, rb;
         int          sel;
         rop = 2'($urandom_range(0, 3));
         rw  = 1'($urandom_range(0, 1));
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         sel = $urandom_range(0, 5);
         case (sel)
            0: rb = rw ? {rb[63:32], 32'd0} : 64'd0;
            1: begin
               rop[0] = 1'b0;
               if (rw) begin
                  ra = {ra[63:32], 32'h8000_0000};
                  rb = {rb[63:32], 32'hFFFF_FFFF};
               end else begin
                  ra = 64'h8000_0000_0000_0000;
                  rb = 64'hFFFF_FFFF_FFFF_FFFF;
               end
            end
            2: rb = 64'($urandom_range(1, 100));
            3: if (rec_v) begin
               ra = rec_a; rb = rec_b; rop[0] = !rec_s; rw = rec_w;
            end
            default: ;
         endcase
         run_req("rand", rop, rw, ra, rb, ref_result(rop, rw, ra, rb), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
